// File: rtl/xbee_uart_fifo.sv
// xbee_uart_fifo: buffered full-duplex UART link for one XBee radio.
//
// A TX FIFO feeds a transmit state machine. A receive state machine with
// start-bit glitch rejection feeds an RX FIFO, which presents its head
// word first-word fall-through.
//
// Optional feature macro: XBEE_PARITY_EN. When it is defined, an even-parity
// bit follows the data bits. TX generates the bit, and RX checks it; a mismatch
// sets frame_err and the word is discarded. When the macro is undefined, a
// frame is start + DATA_WIDTH data bits + stop.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   tx_data, tx_wr       word to send and its push strobe (ignored when tx_full)
//   tx_full              TX FIFO full
//   rx_rd                pop RX FIFO head (ignored when rx_empty)
//   rx_data              RX FIFO head, 0 while empty
//   rx_empty, rx_count   RX FIFO empty flag and occupancy
//   RxD, TxD             serial line from / to the radio (RxD asynchronous)
//   err_clr              clears both sticky error flags
//   frame_err            sticky: bad stop bit (or parity) seen
//   overrun              sticky: word arrived while RX FIFO full
module xbee_uart_fifo #(
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int CLKFREQ    = 100_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_wr,
    output logic                          tx_full,
    input  logic                          rx_rd,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_empty,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    input  logic                          RxD,
    output logic                          TxD,
    input  logic                          err_clr,
    output logic                          frame_err,
    output logic                          overrun
);
    localparam int BIT_TICKS  = CLKFREQ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CW         = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PW + 1;
    localparam int BW         = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]    TICK_LAST = CW'(BIT_TICKS - 1);
    localparam logic [CW-1:0]    TICK_HALF = CW'(HALF_TICKS - 1);
    localparam logic [BW-1:0]    BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

`ifdef XBEE_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // TX FIFO
    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0]         tx_wp, tx_rp;
    logic [CNT_W-1:0]      tx_cnt;
    logic                  tx_empty, tx_push, tx_pop;

    assign tx_full  = (tx_cnt == DEPTH);
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = tx_wr && !tx_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= tx_data;
    end

    // TX state machine
    state_t                tx_state, tx_state_nx;
    logic [CW-1:0]         tx_tick;
    logic [BW-1:0]         tx_bit;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_tick_end;
`ifdef XBEE_PARITY_EN
    logic                  tx_par;
`endif

    assign tx_tick_end = (tx_tick == TICK_LAST);

    always_comb begin
        tx_state_nx = tx_state;
        tx_pop      = 1'b0;
        TxD         = 1'b1;
        case (tx_state)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_state_nx = S_START;
                    tx_pop      = 1'b1;
                end
            end
            S_START: begin
                TxD = 1'b0;
                if (tx_tick_end) tx_state_nx = S_DATA;
            end
            S_DATA: begin
                TxD = tx_shift[0];
                if (tx_tick_end && tx_bit == BIT_LAST) begin
`ifdef XBEE_PARITY_EN
                    tx_state_nx = S_PARITY;
`else
                    tx_state_nx = S_STOP;
`endif
                end
            end
            S_PARITY: begin
`ifdef XBEE_PARITY_EN
                TxD = tx_par;
                if (tx_tick_end) tx_state_nx = S_STOP;
`else
                tx_state_nx = S_IDLE;
`endif
            end
            S_STOP: begin
                // Chain straight into the next start bit so back-to-back
                // frames leave no idle gap on the line.
                if (tx_tick_end) begin
                    if (!tx_empty) begin
                        tx_state_nx = S_START;
                        tx_pop      = 1'b1;
                    end else begin
                        tx_state_nx = S_IDLE;
                    end
                end
            end
            default: tx_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_state_nx;
            if (tx_state == S_IDLE || tx_tick_end) tx_tick <= '0;
            else                                   tx_tick <= tx_tick + 1'b1;
            if (tx_state == S_DATA && tx_tick_end)
                tx_bit <= (tx_bit == BIT_LAST) ? '0 : tx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_pop) begin
            tx_shift <= tx_mem[tx_rp];
`ifdef XBEE_PARITY_EN
            tx_par   <= even_parity(tx_mem[tx_rp]);
`endif
        end else if (tx_state == S_DATA && tx_tick_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // RX synchroniser, idle-high so reset cannot fake a start edge
    logic rx_s1, rx_s2, rx_prev, rx_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RxD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;

    // RX state machine
    state_t                rx_state, rx_state_nx;
    logic [CW-1:0]         rx_tick;
    logic [BW-1:0]         rx_bit;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_tick_end, rx_half_end, rx_push, rx_bad, rx_par_ok;
`ifdef XBEE_PARITY_EN
    logic                  rx_par;
    assign rx_par_ok = (even_parity(rx_shift) == rx_par);
`else
    assign rx_par_ok = 1'b1;
`endif

    assign rx_tick_end = (rx_tick == TICK_LAST);
    assign rx_half_end = (rx_tick == TICK_HALF);

    always_comb begin
        rx_state_nx = rx_state;
        rx_push     = 1'b0;
        rx_bad      = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_state_nx = S_START;
            S_START: begin
                // Mid-start resample: a line back high means a glitch.
                if (rx_half_end) rx_state_nx = rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (rx_tick_end && rx_bit == BIT_LAST) begin
`ifdef XBEE_PARITY_EN
                    rx_state_nx = S_PARITY;
`else
                    rx_state_nx = S_STOP;
`endif
                end
            end
            S_PARITY: begin
`ifdef XBEE_PARITY_EN
                if (rx_tick_end) rx_state_nx = S_STOP;
`else
                rx_state_nx = S_IDLE;
`endif
            end
            S_STOP: begin
                if (rx_tick_end) begin
                    rx_state_nx = S_IDLE;
                    if (rx_s2 && rx_par_ok) rx_push = 1'b1;
                    else                    rx_bad  = 1'b1;
                end
            end
            default: rx_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nx;
            if (rx_state == S_IDLE ||
                ((rx_state == S_START) ? rx_half_end : rx_tick_end))
                rx_tick <= '0;
            else
                rx_tick <= rx_tick + 1'b1;
            if (rx_state == S_DATA && rx_tick_end)
                rx_bit <= (rx_bit == BIT_LAST) ? '0 : rx_bit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_state == S_DATA && rx_tick_end) rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
`ifdef XBEE_PARITY_EN
        if (rx_state == S_PARITY && rx_tick_end) rx_par <= rx_s2;
`endif
    end

    // RX FIFO; a pop in the same cycle frees the slot a full-FIFO push needs
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]         rx_wp, rx_rp;
    logic [CNT_W-1:0]      rx_cnt;
    logic                  rx_full, rx_pop, rx_wr;

    assign rx_full  = (rx_cnt == DEPTH);
    assign rx_empty = (rx_cnt == '0);
    assign rx_pop   = rx_rd && !rx_empty;
    assign rx_wr    = rx_push && (!rx_full || rx_pop);
    assign rx_count = rx_cnt;
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_wr)  rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (rx_wr && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_wr && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wp] <= rx_shift;
    end

    // Sticky error flags; a clear wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_bad)              frame_err <= 1'b1;
            if (rx_push && !rx_wr)   overrun   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xbee_uart_fifo.sv
module tb_xbee_uart_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic [2:0] rx_count;
    logic       rxd_line;
    logic       TxD;
    logic       err_clr = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       loop = 1'b0;
    logic       rxd_drv = 1'b1;

    int checks = 0;
    int errors = 0;

    assign rxd_line = loop ? TxD : rxd_drv;

    always #5 clk = ~clk;

    xbee_uart_fifo #(
        .BAUD(100_000), .DATA_WIDTH(8), .CLKFREQ(1_000_000), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
        .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .rx_count(rx_count),
        .RxD(rxd_line), .TxD(TxD), .err_clr(err_clr), .frame_err(frame_err),
        .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic push_tx(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic pop_rx();
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Waits for a start bit, then checks all ten bits are held ten cycles each.
    task automatic tx_expect(input logic [7:0] b, output int waited);
        logic [9:0] fr;
        logic [9:0] s;
        fr = {1'b1, b, 1'b0};
        waited = 0;
        while (TxD !== 1'b0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 300) begin
            chk("tx_start_timeout", 32'(TxD), 32'd0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                for (int c = 0; c < 10; c++) begin
                    if (!(i == 0 && c == 0)) @(negedge clk);
                    s[c] = TxD;
                end
                chk($sformatf("tx_%02h_bit%0d", b, i), 32'(s), fr[i] ? 32'h3FF : 32'h0);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd_drv = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (10) @(negedge clk);
        end
        rxd_drv = stop;
        repeat (10) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_rx_count(input logic [2:0] n, input int budget);
        int k;
        k = 0;
        while (rx_count !== n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("rx_count_wait", 32'(rx_count), 32'(n));
    endtask

    initial begin
        int w;
        int lows;

        // 1: reset state, single frame
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_txd", 32'(TxD), 32'd1);
        chk("rst_tx_full", 32'(tx_full), 32'd0);
        chk("rst_rx_empty", 32'(rx_empty), 32'd1);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        push_tx(8'hA5);
        tx_expect(8'hA5, w);

        // 2: back-to-back frames, no gap
        repeat (5) @(negedge clk);
        push_tx(8'h3C);
        push_tx(8'hC3);
        chk("b2b_tx_full", 32'(tx_full), 32'd0);
        tx_expect(8'h3C, w);
        tx_expect(8'hC3, w);
        chk("b2b_gap", 32'(w), 32'd1);

        // 3: loopback
        repeat (5) @(negedge clk);
        loop = 1'b1;
        push_tx(8'h55);
        push_tx(8'h0F);
        wait_rx_count(3'd2, 400);
        chk("loop_rx_data0", 32'(rx_data), 32'h55);
        pop_rx();
        chk("loop_rx_data1", 32'(rx_data), 32'h0F);
        pop_rx();
        chk("loop_rx_empty", 32'(rx_empty), 32'd1);
        repeat (20) @(negedge clk);
        loop = 1'b0;

        // 4: overrun
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        chk("ovr_before", 32'(overrun), 32'd0);
        send_frame(8'h55, 1'b1);
        chk("ovr_count", 32'(rx_count), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_head", 32'(rx_data), 32'h11);
        chk("ovr_ferr", 32'(frame_err), 32'd0);
        pulse_err_clr();
        chk("ovr_clr", 32'(overrun), 32'd0);
        pop_rx();
        chk("ovr_head2", 32'(rx_data), 32'h22);
        repeat (3) pop_rx();
        chk("ovr_drained", 32'(rx_empty), 32'd1);

        // 5: framing error and glitch rejection
        send_frame(8'h77, 1'b1);
        chk("fe_good_count", 32'(rx_count), 32'd1);
        send_frame(8'h66, 1'b0);
        chk("fe_flag", 32'(frame_err), 32'd1);
        chk("fe_count", 32'(rx_count), 32'd1);
        chk("fe_head", 32'(rx_data), 32'h77);
        pulse_err_clr();
        chk("fe_clr", 32'(frame_err), 32'd0);
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_count", 32'(rx_count), 32'd1);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        send_frame(8'h5A, 1'b1);
        chk("after_glitch_count", 32'(rx_count), 32'd2);

        // 6: reset mid-frame
        send_frame(8'h99, 1'b0);
        chk("pre_rst_ferr", 32'(frame_err), 32'd1);
        push_tx(8'h00);
        push_tx(8'hFF);
        w = 0;
        while (TxD !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (45) @(negedge clk);
        chk("mid_txd_low", 32'(TxD), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_txd", 32'(TxD), 32'd1);
        chk("mrst_tx_full", 32'(tx_full), 32'd0);
        chk("mrst_rx_empty", 32'(rx_empty), 32'd1);
        chk("mrst_rx_count", 32'(rx_count), 32'd0);
        chk("mrst_rx_data", 32'(rx_data), 32'd0);
        chk("mrst_ferr", 32'(frame_err), 32'd0);
        chk("mrst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (TxD !== 1'b1) lows++;
        end
        chk("mrst_tx_flushed", 32'(lows), 32'd0);
        push_tx(8'h96);
        tx_expect(8'h96, w);

        // TX FIFO fill: one word in the shifter plus four queued
        repeat (5) @(negedge clk);
        push_tx(8'h01);
        push_tx(8'h02);
        push_tx(8'h03);
        push_tx(8'h04);
        chk("tx_not_full", 32'(tx_full), 32'd0);
        push_tx(8'h05);
        chk("tx_full", 32'(tx_full), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
